// File: rtl/id_decode_stage.sv
// Pipelined RV32I decode stage: combinational decode feeding an output register plus a one-entry skid buffer.
// Define ID_RV32M_EN to decode the RV32M multiply/divide group (OP with funct7=0000001).
module id_decode_stage #(
  parameter int XLEN  = 32,
  parameter int ALU_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ALU_W-1:0] alu_type_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             reg_we_o,
  output logic             mem_rd_o,
  output logic             mem_wr_o,
  output logic             illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_SLL   = 5'd3;
  localparam logic [4:0] ALU_SLT   = 5'd4;
  localparam logic [4:0] ALU_SLTU  = 5'd5;
  localparam logic [4:0] ALU_XOR   = 5'd6;
  localparam logic [4:0] ALU_SRL   = 5'd7;
  localparam logic [4:0] ALU_SRA   = 5'd8;
  localparam logic [4:0] ALU_OR    = 5'd9;
  localparam logic [4:0] ALU_AND   = 5'd10;
  localparam logic [4:0] ALU_PASSB = 5'd11;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [XLEN-1:0]  imm;
    logic             regWe;
    logic             memRd;
    logic             memWr;
    logic             illegal;
  } decode_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t  state_q;
  decode_t outData_q, skidData_q, decode_d;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] aluCode;
  logic       legal;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  // Register-register ALU ops with funct7=0 share the funct3 ordering of the immediate forms.
  function automatic logic [4:0] baseOp(input logic [2:0] f3);
    case (f3)
      3'd0:    baseOp = ALU_ADD;
      3'd1:    baseOp = ALU_SLL;
      3'd2:    baseOp = ALU_SLT;
      3'd3:    baseOp = ALU_SLTU;
      3'd4:    baseOp = ALU_XOR;
      3'd5:    baseOp = ALU_SRL;
      3'd6:    baseOp = ALU_OR;
      default: baseOp = ALU_AND;
    endcase
  endfunction

  always_comb begin
    decode_d = '0;
    aluCode  = ALU_NOP;
    legal    = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal          = 1'b1;
        decode_d.regWe = 1'b1;
        decode_d.rd    = inst_i[11:7];
        decode_d.rs1   = inst_i[19:15];
        decode_d.rs2   = inst_i[24:20];
        case (funct7)
          7'b0000000: aluCode = baseOp(funct3);
          7'b0100000: begin
            if (funct3 == 3'd0)      aluCode = ALU_SUB;
            else if (funct3 == 3'd5) aluCode = ALU_SRA;
            else                     legal   = 1'b0;
          end
`ifdef ID_RV32M_EN
          7'b0000001: aluCode = 5'd16 + {2'b00, funct3};
`endif
          default:    legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal          = 1'b1;
        decode_d.regWe = 1'b1;
        decode_d.rd    = inst_i[11:7];
        decode_d.rs1   = inst_i[19:15];
        decode_d.imm   = XLEN'($signed(inst_i[31:20]));
        aluCode        = baseOp(funct3);
        if (funct3 == 3'd1 && funct7 != 7'b0000000) begin
          legal = 1'b0;
        end else if (funct3 == 3'd5) begin
          if (funct7 == 7'b0100000)      aluCode = ALU_SRA;
          else if (funct7 != 7'b0000000) legal   = 1'b0;
        end
      end
      OPC_LUI: begin
        legal          = 1'b1;
        aluCode        = ALU_PASSB;
        decode_d.regWe = 1'b1;
        decode_d.rd    = inst_i[11:7];
        decode_d.imm   = XLEN'($signed({inst_i[31:12], 12'b0}));
      end
      OPC_LOAD: begin
        legal          = 1'b1;
        aluCode        = ALU_ADD;
        decode_d.regWe = 1'b1;
        decode_d.memRd = 1'b1;
        decode_d.rd    = inst_i[11:7];
        decode_d.rs1   = inst_i[19:15];
        decode_d.imm   = XLEN'($signed(inst_i[31:20]));
      end
      OPC_STORE: begin
        legal          = 1'b1;
        aluCode        = ALU_ADD;
        decode_d.memWr = 1'b1;
        decode_d.rs1   = inst_i[19:15];
        decode_d.rs2   = inst_i[24:20];
        decode_d.imm   = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      decode_d.alu = ALU_W'(aluCode);
    end else begin
      decode_d         = '0;
      decode_d.illegal = 1'b1;
    end
  end

  // Occupancy FSM; the skid slot only fills when EX stalls while the output register is held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      outData_q  <= '0;
      skidData_q <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid_i) begin
            outData_q <= decode_d;
            state_q   <= FULL;
          end
        end
        FULL: begin
          if (in_valid_i && out_ready_i) begin
            outData_q <= decode_d;
          end else if (in_valid_i) begin
            skidData_q <= decode_d;
            state_q    <= SKID;
          end else if (out_ready_i) begin
            state_q <= EMPTY;
          end
        end
        SKID: begin
          if (out_ready_i) begin
            outData_q <= skidData_q;
            state_q   <= FULL;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign in_ready_o  = (state_q != SKID);
  assign out_valid_o = (state_q != EMPTY);
  assign alu_type_o  = outData_q.alu;
  assign rd_o        = outData_q.rd;
  assign rs1_o       = outData_q.rs1;
  assign rs2_o       = outData_q.rs2;
  assign imm_o       = outData_q.imm;
  assign reg_we_o    = outData_q.regWe;
  assign mem_rd_o    = outData_q.memRd;
  assign mem_wr_o    = outData_q.memWr;
  assign illegal_o   = outData_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed scenarios plus randomized traffic against a queue-based model.
// Honours ID_RV32M_EN the same way as the design.
module tb_id_decode_stage;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst, imm;
  logic [4:0]  alu_type, rd, rs1, rs2;
  logic        reg_we, mem_rd, mem_wr, illegal;
  logic [55:0] obs;
  int          tests = 0;
  int          fails = 0;
  int          rTab [8] = '{1, 3, 4, 5, 6, 7, 9, 10};

  typedef struct {
    logic [55:0] v;
    logic [55:0] m;
  } exp_t;

  id_decode_stage #(.XLEN(32), .ALU_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .inst_i(inst),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_type_o(alu_type), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .imm_o(imm),
    .reg_we_o(reg_we), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .illegal_o(illegal)
  );

  assign obs = {alu_type, rd, rs1, rs2, imm, reg_we, mem_rd, mem_wr, illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected decode built from instruction-format rules with integer arithmetic.
  function automatic exp_t model(input logic [31:0] w);
    exp_t        e;
    int          op = int'(w[6:0]);
    int          f3 = int'(w[14:12]);
    int          f7 = int'(w[31:25]);
    int          alu = 0, rdN = int'(w[11:7]), r1 = int'(w[19:15]), r2 = int'(w[24:20]);
    int          v;
    logic [31:0] im = 0;
    bit          we = 0, mr = 0, mw = 0, ill = 0;
    case (op)
      'h33: begin
        we = 1;
        if (f7 == 0) alu = rTab[f3];
        else if (f7 == 'h20 && f3 == 0) alu = 2;
        else if (f7 == 'h20 && f3 == 5) alu = 8;
`ifdef ID_RV32M_EN
        else if (f7 == 1) alu = 16 + f3;
`endif
        else ill = 1;
      end
      'h13: begin
        we = 1; r2 = 0;
        v = int'(w[31:20]); if (v >= 2048) v -= 4096; im = v;
        if (f3 == 1) begin if (f7 == 0) alu = 3; else ill = 1; end
        else if (f3 == 5) begin
          if (f7 == 0) alu = 7; else if (f7 == 'h20) alu = 8; else ill = 1;
        end else alu = rTab[f3];
      end
      'h37: begin
        we = 1; alu = 11; r1 = 0; r2 = 0; im = {w[31:12], 12'h000};
      end
      'h03: begin
        we = 1; mr = 1; alu = 1; r2 = 0;
        v = int'(w[31:20]); if (v >= 2048) v -= 4096; im = v;
      end
      'h23: begin
        mw = 1; alu = 1;
        v = int'({w[31:25], w[11:7]}); if (v >= 2048) v -= 4096; im = v;
      end
      default: ill = 1;
    endcase
    e.m = '1;
    if (ill) begin
      alu = 0; we = 0; mr = 0; mw = 0;
      e.m = {5'h1f, 5'h1f, 5'h00, 5'h00, 32'h0, 4'hf};
    end
    if (!we) rdN = 0;
    e.v = {5'(alu), 5'(rdN), 5'(r1), 5'(r2), im, we, mr, mw, ill};
    return e;
  endfunction

  function automatic logic [31:0] randInst();
    logic [31:0] w = $urandom;
    int          pick = $urandom_range(0, 9);
    int          sel  = $urandom_range(0, 3);
    logic [6:0]  f7 = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : w[31:25];
    case (pick)
      0, 1, 7: begin w[6:0] = 7'h33; w[31:25] = f7; end
      2, 3:    begin w[6:0] = 7'h13; w[31:25] = f7; end
      4:       w[6:0] = 7'h37;
      5:       w[6:0] = 7'h03;
      6:       w[6:0] = 7'h23;
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_reset();
    rst = 1; flush = 0; in_valid = 1; inst = 32'h00B50533; out_ready = 0;
    tick(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (obs !== 56'h0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", obs); end
    rst = 0; in_valid = 0;
  endtask

  task automatic test_add();
    logic [55:0] want = {5'd1, 5'd10, 5'd10, 5'd11, 32'h0, 4'b1000};
    out_ready = 1; in_valid = 1; inst = 32'h00B50533;
    tick();
    in_valid = 0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL add_valid: got %b expected 1", out_valid); end
    tests++; if (obs !== want) begin fails++; $display("[TB] FAIL add_fields: got %h expected %h", obs, want); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL add_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] wantSub  = {5'd2, 5'd5, 5'd6, 5'd7, 32'h0, 4'b1000};
    logic [55:0] wantAddi = {5'd1, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 4'b1000};
    logic [55:0] wantSw   = {5'd1, 5'd0, 5'd1, 5'd2, 32'd8, 4'b0010};
    out_ready = 1; in_valid = 1; inst = 32'h407302B3;
    tick();
    inst = 32'hFFF00093;
    tests++; if (obs !== wantSub) begin fails++; $display("[TB] FAIL b2b_sub: got %h expected %h", obs, wantSub); end
    tick();
    inst = 32'h0020A423;
    tests++; if (obs !== wantAddi || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_addi: got %h v=%b expected %h v=1", obs, out_valid, wantAddi); end
    tick();
    in_valid = 0;
    tests++; if (obs !== wantSw || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL store: got %h v=%b expected %h v=1", obs, out_valid, wantSw); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] seq [3] = '{32'h00B50533, 32'h407302B3, 32'h0020A423};
    exp_t        e0 = model(seq[0]);
    exp_t        e1 = model(seq[1]);
    exp_t        e2 = model(seq[2]);
    out_ready = 0; in_valid = 1; inst = seq[0];
    tick();
    inst = seq[1];
    tests++; if (in_ready !== 1'b1 || obs !== e0.v) begin fails++; $display("[TB] FAIL bp_first: got rdy=%b %h expected rdy=1 %h", in_ready, obs, e0.v); end
    tick();
    inst = seq[2];
    tests++; if (in_ready !== 1'b0 || obs !== e0.v) begin fails++; $display("[TB] FAIL bp_skid: got rdy=%b %h expected rdy=0 %h", in_ready, obs, e0.v); end
    tick();
    tests++; if (in_ready !== 1'b0 || obs !== e0.v || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_hold: got rdy=%b %h expected rdy=0 %h", in_ready, obs, e0.v); end
    out_ready = 1;
    tick();
    tests++; if (in_ready !== 1'b1 || obs !== e1.v) begin fails++; $display("[TB] FAIL bp_second: got rdy=%b %h expected rdy=1 %h", in_ready, obs, e1.v); end
    tick();
    in_valid = 0;
    tests++; if (out_valid !== 1'b1 || obs !== e2.v) begin fails++; $display("[TB] FAIL bp_third: got v=%b %h expected v=1 %h", out_valid, obs, e2.v); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_mul();
`ifdef ID_RV32M_EN
    logic [55:0] want = {5'd16, 5'd3, 5'd1, 5'd2, 32'h0, 4'b1000};
    logic [55:0] msk  = '1;
`else
    logic [55:0] want = {5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 4'b0001};
    logic [55:0] msk  = {5'h1f, 5'h1f, 5'h00, 5'h00, 32'h0, 4'hf};
`endif
    out_ready = 1; in_valid = 1; inst = 32'h022081B3;
    tick();
    in_valid = 0;
    tests++; if ((obs & msk) !== want || out_valid !== 1'b1) begin fails++; $display("[TB] FAIL mul: got %h v=%b expected %h v=1", obs & msk, out_valid, want); end
    tick();
  endtask

  task automatic test_flush_reset();
    out_ready = 0; in_valid = 1; inst = 32'h00B50533;
    tick(); tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL flush_setup: got rdy=%b expected 0", in_ready); end
    flush = 1;
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("[TB] FAIL flush_skid: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush_drop_input: got %b expected 0", out_valid); end
    flush = 0;
    tick();
    rst = 1; inst = 32'hFFF00093;
    tick();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== 56'h0) begin fails++; $display("[TB] FAIL rst_mid: got v=%b rdy=%b %h expected v=0 rdy=1 0", out_valid, in_ready, obs); end
    rst = 0; in_valid = 0; out_ready = 1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_no_deliver: got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    exp_t        q [$];
    logic [31:0] w;
    bit          iv, ordy, fl, inFire, outFire;
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 1500; c++) begin
      tests++; if (out_valid !== (q.size() > 0)) begin fails++; $display("[TB] FAIL rnd_valid c=%0d: got %b expected %b", c, out_valid, q.size() > 0); end
      tests++; if (in_ready !== (q.size() < 2)) begin fails++; $display("[TB] FAIL rnd_ready c=%0d: got %b expected %b", c, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        tests++;
        if ((obs & q[0].m) !== (q[0].v & q[0].m)) begin fails++; $display("[TB] FAIL rnd_data c=%0d: got %h expected %h", c, obs & q[0].m, q[0].v & q[0].m); end
      end
      iv = ($urandom_range(0, 3) != 0); ordy = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 39) == 0); w = randInst();
      in_valid = iv; out_ready = ordy; flush = fl; inst = w;
      inFire = iv && (q.size() < 2); outFire = ordy && (q.size() > 0);
      tick();
      if (fl) q.delete();
      else begin
        if (outFire) void'(q.pop_front());
        if (inFire) q.push_back(model(w));
      end
    end
    in_valid = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_mul();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
